// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the FSM state encoding, the one-hot {lt, eq, gt} result
// encoding and the helper that derives the bits_used counter width.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result vector ordering is {lt, eq, gt}
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes
    function automatic int cw_for(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Operand/result bus of the serial magnitude comparator.
// Operand side: in_valid/in_ready handshake, a_i, b_i, signed_i and the
// lt_i/eq_i/gt_i cascade inputs from a less-significant block.
// Result side: out_valid/out_ready handshake, one-hot a_lt_b/a_eq_b/a_gt_b
// and bits_used (number of bit positions examined).
// master = producer of operands / consumer of results, slave = comparator.
interface serial_mag_comparator_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cw_for(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             signed_i;
    logic             lt_i;
    logic             eq_i;
    logic             gt_i;
    logic             out_valid;
    logic             out_ready;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             a_gt_b;
    logic [CW-1:0]    bits_used;

    modport master (
        output in_valid, a_i, b_i, signed_i, lt_i, eq_i, gt_i, out_ready,
        input  in_ready, out_valid, a_lt_b, a_eq_b, a_gt_b, bits_used
    );

    modport slave (
        input  in_valid, a_i, b_i, signed_i, lt_i, eq_i, gt_i, out_ready,
        output in_ready, out_valid, a_lt_b, a_eq_b, a_gt_b, bits_used
    );
endinterface

// File: rtl/cmp_bit_cell.sv
// Combinational 1-bit cascade cell.
// Ports: a, b       - operand bits at the current position
//        invert     - swap the bit-compare sense (sign bit of a signed compare)
//        lt_in, eq_in, gt_in - verdict of the less-significant positions
//        lt, eq, gt - one-hot verdict including this position
module cmp_bit_cell (
    input  logic a,
    input  logic b,
    input  logic invert,
    input  logic lt_in,
    input  logic eq_in,
    input  logic gt_in,
    output logic lt,
    output logic eq,
    output logic gt
);

    // A differing bit decides on its own; otherwise the cascade is resolved
    // with priority gt > lt > eq, and an all-zero cascade counts as equal.
    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        if (a != b) begin
            if (a ^ invert) gt = 1'b1;
            else            lt = 1'b1;
        end else if (gt_in) begin
            gt = 1'b1;
        end else if (lt_in) begin
            lt = 1'b1;
        end else begin
            eq = eq_in | ~(lt_in | gt_in);
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Stops at the first differing bit; if all bits match the latched cascade
// inputs decide, so several blocks can be chained for wider operands.
// Ports: clk, rst_n (async, active-low) and the slave side of
// serial_mag_comparator_if (operand and result handshakes).
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cw_for(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    serial_mag_comparator_if.slave bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [2:0]       res;

    logic bit_a;
    logic bit_b;
    logic msb_swap;
    logic cell_lt;
    logic cell_eq;
    logic cell_gt;

    assign bit_a    = a_q[idx];
    assign bit_b    = b_q[idx];
    // Two's complement: a set sign bit means the smaller value
    assign msb_swap = signed_q && (idx == MSB_IDX);

    cmp_bit_cell u_cell (
        .a      (bit_a),
        .b      (bit_b),
        .invert (msb_swap),
        .lt_in  (lt_q),
        .eq_in  (eq_q),
        .gt_in  (gt_q),
        .lt     (cell_lt),
        .eq     (cell_eq),
        .gt     (cell_gt)
    );

    // Control FSM; the cascade inputs stay latched for the whole scan and
    // only matter when the scan reaches bit 0 without finding a difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            idx      <= MSB_IDX;
            cnt      <= '0;
            res      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a_i;
                        b_q      <= bus.b_i;
                        signed_q <= bus.signed_i;
                        lt_q     <= bus.lt_i;
                        eq_q     <= bus.eq_i;
                        gt_q     <= bus.gt_i;
                        idx      <= MSB_IDX;
                        cnt      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    cnt <= cnt + CW'(1);
                    if ((bit_a != bit_b) || (idx == '0)) begin
                        res   <= {cell_lt, cell_eq, cell_gt};
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.a_lt_b    = res[2];
    assign bus.a_eq_b    = res[1];
    assign bus.a_gt_b    = res[0];
    assign bus.bits_used = cnt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8).
// Stimulus pushes hand-computed expectations into a scoreboard queue; a
// monitor pops one entry each time a new result is presented and checks
// the one-hot result, bits_used and the accept-to-valid latency.
module tb_serial_mag_comparator;

    localparam int WIDTH = 8;
    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         bits;
        int         accept;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic seen;
    int   acc1, acc2, acc3;

    serial_mag_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Presents one operand set at a negedge and waits (bounded) for the
    // accept edge; returns at the negedge following that edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                                 input logic lt, input logic eq, input logic gt,
                                 input logic [2:0] exp_res, input int exp_bits,
                                 input bit keep_valid, output int accept_cycle);
        exp_t e;
        int   n;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = sgn;
        bus.lt_i     = lt;
        bus.eq_i     = eq;
        bus.gt_i     = gt;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        accept_cycle = -1;
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected in_ready=1");
            bus.in_valid = 1'b0;
            return;
        end
        accept_cycle = cycle + 1;
        e.res    = exp_res;
        e.bits   = exp_bits;
        e.accept = accept_cycle;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got in_ready=0 expected in_ready=1");
        end
    endtask

    task automatic waitForResult();
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: got out_valid=0 expected out_valid=1");
        end
    endtask

    // Monitor: first negedge of each out_valid window consumes one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got out_valid=1 expected no result");
            end else begin
                e = sb.pop_front();
                checkOutput("result_lt_eq_gt", int'({bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}), int'(e.res));
                checkOutput("bits_used", int'(bus.bits_used), e.bits);
                checkOutput("latency", cycle - e.accept, e.bits);
            end
        end else if (!bus.out_valid) begin
            seen = 1'b0;
        end
    end

    initial begin
        int acc;
        int n;
        cycle  = 0;
        checks = 0;
        errors = 0;
        seen   = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.signed_i  = 1'b0;
        bus.lt_i      = 1'b0;
        bus.eq_i      = 1'b0;
        bus.gt_i      = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_result", int'({bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}), 0);
        checkOutput("rst_bits_used", int'(bus.bits_used), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] test 1: MSB decides");
        applyStimulus(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 1, 1'b0, acc);
        waitIdle();

        $display("[TB] test 2: equal operands, cascade decides");
        applyStimulus(8'h35, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0, R_LT, 8, 1'b0, acc);
        waitIdle();
        applyStimulus(8'h35, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0, R_EQ, 8, 1'b0, acc);
        waitIdle();
        applyStimulus(8'h35, 8'h35, 1'b0, 1'b1, 1'b0, 1'b1, R_GT, 8, 1'b0, acc);
        waitIdle();
        applyStimulus(8'h35, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0, R_EQ, 8, 1'b0, acc);
        waitIdle();

        $display("[TB] test 3: signed vs unsigned");
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 1, 1'b0, acc);
        waitIdle();
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 1, 1'b0, acc);
        waitIdle();
        applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 1, 1'b0, acc);
        waitIdle();
        applyStimulus(8'h05, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 7, 1'b0, acc);
        waitIdle();
        applyStimulus(8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, R_LT, 8, 1'b0, acc);
        waitIdle();

        $display("[TB] test 4: result held under backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(8'h12, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, R_LT, 8, 1'b0, acc);
        waitForResult();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.a_i      = 8'hAA;
            bus.b_i      = 8'h55;
            checkOutput("hold_out_valid", int'(bus.out_valid), 1);
            checkOutput("hold_in_ready", int'(bus.in_ready), 0);
            checkOutput("hold_a_lt_b", int'(bus.a_lt_b), 1);
            checkOutput("hold_bits_used", int'(bus.bits_used), 8);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("consume_in_ready", int'(bus.in_ready), 1);
        checkOutput("consume_out_valid", int'(bus.out_valid), 0);
        checkOutput("consume_result_held", int'(bus.a_lt_b), 1);
        @(negedge clk);
        checkOutput("ignored_in_valid", int'(bus.in_ready), 1);

        $display("[TB] test 5: reset during scan");
        applyStimulus(8'h35, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0, R_EQ, 8, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("async_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("async_rst_result", int'({bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}), 0);
        checkOutput("async_rst_bits_used", int'(bus.bits_used), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", int'(bus.in_ready), 1);
        applyStimulus(8'h3C, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 6, 1'b0, acc);
        waitIdle();

        $display("[TB] test 6: back-to-back");
        applyStimulus(8'hA1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, R_GT, 1, 1'b1, acc1);
        applyStimulus(8'h44, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, R_LT, 7, 1'b1, acc2);
        applyStimulus(8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, R_GT, 1, 1'b0, acc3);
        checkOutput("b2b_spacing_1", acc2 - acc1, 3);
        checkOutput("b2b_spacing_2", acc3 - acc2, 9);
        waitIdle();

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, one bit per clock, and stops at the first bit where they differ.
- Keeps the three-way cascade inputs (lt/eq/gt) so that wider compares can be chained from several blocks.
- Adds a signed mode and valid/ready handshakes on both the operand side and the result side.
- Used wherever area matters more than latency, e.g. sort and threshold units in the lab datapath.

Parameters:
- WIDTH, default 8: operand width in bits; legal range is 2 or more.
- CW, default $clog2(WIDTH+1): width of the bits_used counter; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- signed_i  in  1  1 = two's-complement compare, 0 = unsigned.
- lt_i  in  1  cascade input: a less-significant stage reports less-than.
- eq_i  in  1  cascade input: a less-significant stage reports equal.
- gt_i  in  1  cascade input: a less-significant stage reports greater-than.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- a_lt_b  out  1  result: A < B.
- a_eq_b  out  1  result: A == B.
- a_gt_b  out  1  result: A > B.
- bits_used  out  CW  number of bit positions examined.

Behaviour:
- Clocking/reset: one clock (clk). Reset is asynchronous and active-low on rst_n. Reset forces state IDLE.
- Reset values: in_ready=1, out_valid=0, a_lt_b=a_eq_b=a_gt_b=0, bits_used=0, internal index=WIDTH-1.
- States: IDLE, SCAN, DONE. in_ready is decoded from state IDLE; out_valid is decoded from state DONE.
- IDLE:
  - On in_valid at a rising edge, latch a_i, b_i, signed_i and the cascade inputs.
  - Set idx=WIDTH-1 and the counter to 0, then go to SCAN.
  - in_valid in any other state is ignored; no operands are latched.
- SCAN, once per cycle:
  - Compare A[idx] with B[idx] and increment the counter.
  - If signed=1 and idx=WIDTH-1, swap the sense of the bit compare: A bit 1 / B bit 0 means A<B.
  - If the bits differ: set exactly one of lt/gt and go to DONE.
  - If the bits are equal and idx==0: take the result from the latched cascade inputs and go to DONE.
  - If the bits are equal and idx>0: decrement idx and stay in SCAN.
- Cascade resolution priority: gt > lt > eq. If none of the three is set, the result is eq.
- DONE:
  - Result outputs and bits_used stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE. Result outputs are held until the next result is written.
- Latency: with d the index of the first differing bit (d=-1 if all bits are equal), bits_used=WIDTH-d, capped at WIDTH. out_valid rises bits_used cycles after the accept edge.
- Throughput: the fastest back-to-back rate is one result per bits_used+2 cycles. in_ready rises the cycle after the result handshake.
- Exactly one of a_lt_b, a_eq_b, a_gt_b is 1 whenever out_valid=1.
- Reset mid-SCAN or mid-DONE: abort immediately, restore all reset values, discard the partial result.

Decomposition:
- Package cmp_pkg holds:
  - the state encoding constants: IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - the result encoding: LT/EQ/GT one-hot;
  - the CW derivation function.
- Sub-module cmp_bit_cell: a combinational 1-bit cascade cell.
  - Inputs: a, b, invert (the signed-MSB swap), lt_in, eq_in, gt_in.
  - Outputs: lt, eq, gt.
  - The FSM holds the running cascade state and reuses this cell every cycle.

Test Plan:
1. WIDTH=8, unsigned, A=8'h80, B=8'h7F -> a_gt_b=1, bits_used=1, out_valid one cycle after the accept edge.
2. A=B=8'h35, unsigned, cascade lt_i=1 -> a_lt_b=1, bits_used=8. Repeat with all cascade inputs 0 -> a_eq_b=1. Repeat with gt_i=lt_i=1 -> a_gt_b=1.
3. Signed, A=8'hFF (-1), B=8'h01 -> a_lt_b=1, bits_used=1. Same operands unsigned -> a_gt_b=1.
4. A=8'h12, B=8'h13, hold out_ready=0 for 5 cycles and pulse in_valid meanwhile -> a_lt_b=1 and bits_used=8 held stable, in_ready=0, extra in_valid ignored; result consumed when out_ready=1.
5. Assert rst_n=0 during the third SCAN cycle -> all outputs at reset values asynchronously; after release in_ready=1 and a fresh compare completes correctly.
6. Back-to-back with out_ready tied 1 and in_valid tied 1 over three operand pairs -> in_ready pulses in the cycle after each result, and every result matches the reference model.
